// File: rtl/ls_sequencer_pkg.sv
// Shared load/store definitions: access-size encodings, sequencer state encoding
// and the alignment rule common to the load/store size logic.
package ls_sequencer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_WR    = 3'd2;
    localparam logic [2:0] ST_FIN   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    typedef struct packed {
        logic        is_store;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ls_req_t;

    // Size 00 is never legal; halves need even and words need 4-byte alignment.
    function automatic logic ls_bad_access(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ls_lane_mux.sv
// Little-endian byte-lane extract (zero-extended) and merge for sub-word accesses.
// Word-sized accesses pass the full word through on extract and wdata on merge.
module ls_lane_mux
    import ls_sequencer_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    always_comb begin
        extracted = word;
        merged    = wdata;
        case (size)
            SZ_BYTE: begin
                extracted = {24'd0, word[{offset, 3'b000} +: 8]};
                merged    = word;
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                extracted = {16'd0, word[{offset[1], 4'b0000} +: 16]};
                merged    = word;
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ls_sequencer.sv
// Load/store sequencer: turns one latched request into a read, a write, or a
// read-modify-write on a word-wide memory port with req/ack handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start; request fields latched on acceptance
// RD       | read cycle, mem_req held until mem_ack
// WR       | write cycle (merged word or full store word), until mem_ack
// FIN      | one-cycle done pulse
// FAULT    | one-cycle err pulse, no memory traffic
module ls_sequencer
    import ls_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data
);

    logic [2:0]  state;
    ls_req_t     req_q;
    logic [31:0] rdata_q;
    logic [31:0] lane_word;
    logic [31:0] extracted;
    logic [31:0] merged;

    // Loads extract straight from the returning bus word; the write merges into the captured one.
    assign lane_word = (state == ST_RD) ? mem_rdata : rdata_q;

    ls_lane_mux u_lane_mux (
        .word      (lane_word),
        .size      (req_q.size),
        .offset    (req_q.addr[1:0]),
        .wdata     (req_q.wdata),
        .extracted (extracted),
        .merged    (merged)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            rdata_q   <= '0;
            load_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req_q.is_store <= is_store;
                        req_q.size     <= size;
                        req_q.addr     <= addr;
                        req_q.wdata    <= wdata;
                        if (ls_bad_access(size, addr[1:0]))
                            state <= ST_FAULT;
                        else if (is_store && size == SZ_WORD)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        if (req_q.is_store) begin
                            state <= ST_WR;
                        end else begin
                            load_data <= extracted;
                            state     <= ST_FIN;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_ack)
                        state <= ST_FIN;
                end
                ST_FIN:   state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = (state == ST_RD) || (state == ST_WR);
    assign mem_we    = (state == ST_WR);
    assign mem_addr  = {req_q.addr[31:2], 2'b00};
    assign mem_wdata = (state == ST_WR) ? merged : 32'd0;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIN);
    assign err       = (state == ST_FAULT);

endmodule
